// File: rtl/imem_fetch_unit.sv
// Instruction-fetch initiator: drives the combinational instruction memory from the PC
// and buffers fetched {pc, instr} pairs in a small prefetch FIFO for decode.
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   pc_mem_d    [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   instr_mem_d [FIFO_DEPTH];
    logic          pop;
    logic          push;

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    always_comb begin
        pop  = out_valid & out_ready;
        push = fetch_en & ~redirect_valid & ((count_q < CW'(FIFO_DEPTH)) | pop);
    end

    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                pc_mem_d[tail_q]    = pc_q;
                instr_mem_d[tail_q] = imem_data;
                tail_d              = tail_q + PW'(1);
                pc_d                = pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the outputs are never X while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pc_mem_q    <= '{default: '0};
            instr_mem_q <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: two instances (default and wrap-around reset PC with a deeper
// FIFO) run the same directed and random stimulus against a list-based reference model.
module tb_imem_fetch_unit;

   localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;
   localparam int          DEPTH_A    = 2;
   localparam int          DEPTH_B    = 4;

   logic        clk = 1'b0;
   logic        rstN;
   logic        fetchEn;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        outReady;

   logic [31:0] imemAddrA, imemDataA, outInstrA, outPcA;
   logic        outValidA;
   logic [31:0] imemAddrB, imemDataB, outInstrB, outPcB;
   logic        outValidB;

   logic [31:0] modelPc     [2];
   logic [31:0] modelQPc    [2][8];
   logic [31:0] modelQInstr [2][8];
   int          modelSize   [2];
   int          depthOf     [2] = '{DEPTH_A, DEPTH_B};
   logic [31:0] resetPcOf   [2] = '{RESET_PC_A, RESET_PC_B};

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   // Memory content: word i of the address space holds 32'h1000_0000 + i.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'h1000_0000 + {2'b00, addr[31:2]};
   endfunction

   assign imemDataA = memWord(imemAddrA);
   assign imemDataB = memWord(imemAddrB);

   imem_fetch_unit #(.RESET_PC(RESET_PC_A), .FIFO_DEPTH(DEPTH_A)) dutA (
      .clk(clk), .rst_n(rstN), .fetch_en(fetchEn),
      .redirect_valid(redirectValid), .redirect_pc(redirectPc),
      .imem_addr(imemAddrA), .imem_data(imemDataA),
      .out_valid(outValidA), .out_ready(outReady),
      .out_instr(outInstrA), .out_pc(outPcA)
   );

   imem_fetch_unit #(.RESET_PC(RESET_PC_B), .FIFO_DEPTH(DEPTH_B)) dutB (
      .clk(clk), .rst_n(rstN), .fetch_en(fetchEn),
      .redirect_valid(redirectValid), .redirect_pc(redirectPc),
      .imem_addr(imemAddrB), .imem_data(imemDataB),
      .out_valid(outValidB), .out_ready(outReady),
      .out_instr(outInstrB), .out_pc(outPcB)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
   endtask

   task automatic resetModel();
      for (int k = 0; k < 2; k++) begin
         modelPc[k]   = resetPcOf[k];
         modelSize[k] = 0;
      end
   endtask

   // The model's FIFO is an ordered list: element 0 is the oldest fetched instruction.
   task automatic compareDut(input int k, input string name, input logic [31:0] addr,
                             input logic valid, input logic [31:0] instr,
                             input logic [31:0] pc);
      checkOutput({name, ".imem_addr"}, addr, modelPc[k]);
      checkOutput({name, ".out_valid"}, {31'b0, valid}, {31'b0, (modelSize[k] != 0)});
      if (modelSize[k] != 0) begin
         checkOutput({name, ".out_pc"}, pc, modelQPc[k][0]);
         checkOutput({name, ".out_instr"}, instr, modelQInstr[k][0]);
      end
   endtask

   // Advance the model by one clock edge with the inputs about to be presented.
   task automatic stepModel(input int k, input logic fe, input logic rv,
                            input logic [31:0] rpc, input logic rdy);
      logic pop;
      logic push;
      pop = (modelSize[k] != 0) && rdy;
      if (rv) begin
         modelSize[k] = 0;
         modelPc[k]   = rpc & 32'hFFFF_FFFC;
      end else begin
         push = fe && ((modelSize[k] < depthOf[k]) || pop);
         if (pop) begin
            for (int i = 0; i < 7; i++) begin
               modelQPc[k][i]    = modelQPc[k][i+1];
               modelQInstr[k][i] = modelQInstr[k][i+1];
            end
            modelSize[k]--;
         end
         if (push) begin
            modelQPc[k][modelSize[k]]    = modelPc[k];
            modelQInstr[k][modelSize[k]] = memWord(modelPc[k]);
            modelSize[k]++;
            modelPc[k] = modelPc[k] + 32'd4;
         end
      end
   endtask

   // Called just after a falling edge: check settled outputs, drive the next inputs,
   // advance the model, then wait for the following falling edge.
   task automatic applyStimulus(input logic fe, input logic rv, input logic [31:0] rpc,
                                input logic rdy);
      compareDut(0, "A", imemAddrA, outValidA, outInstrA, outPcA);
      compareDut(1, "B", imemAddrB, outValidB, outInstrB, outPcB);
      fetchEn       = fe;
      redirectValid = rv;
      redirectPc    = rpc;
      outReady      = rdy;
      stepModel(0, fe, rv, rpc, rdy);
      stepModel(1, fe, rv, rpc, rdy);
      @(negedge clk);
   endtask

   task automatic randomCycles(input int n);
      logic [31:0] rpc;
      for (int i = 0; i < n; i++) begin
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                           : $urandom_range(0, 255);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc,
                       $urandom_range(0, 4) < 3);
      end
   endtask

   initial begin
      rstN          = 1'b0;
      fetchEn       = 1'b0;
      redirectValid = 1'b0;
      redirectPc    = 32'h0;
      outReady      = 1'b0;
      resetModel();
      @(negedge clk);
      @(negedge clk);

      checkOutput("A.reset_valid", {31'b0, outValidA}, 32'h0);
      checkOutput("A.reset_instr", outInstrA, 32'h0);
      checkOutput("A.reset_pc", outPcA, 32'h0);
      checkOutput("A.reset_addr", imemAddrA, RESET_PC_A);
      checkOutput("B.reset_valid", {31'b0, outValidB}, 32'h0);
      checkOutput("B.reset_instr", outInstrB, 32'h0);
      checkOutput("B.reset_pc", outPcB, 32'h0);
      checkOutput("B.reset_addr", imemAddrB, RESET_PC_B);

      rstN = 1'b1;

      // Streaming with decode always ready.
      repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

      // Decode stalls, FIFO fills, then drains in order.
      repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

      // Redirect to an unaligned target while full.
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0043, 1'b0);
      repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

      // Fetch-enable hold pattern.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

      randomCycles(400);

      // Asynchronous reset in the middle of a full FIFO, checked before the next edge.
      repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      #2 rstN = 1'b0;
      #1;
      checkOutput("A.async_valid", {31'b0, outValidA}, 32'h0);
      checkOutput("A.async_addr", imemAddrA, RESET_PC_A);
      checkOutput("B.async_valid", {31'b0, outValidB}, 32'h0);
      checkOutput("B.async_addr", imemAddrB, RESET_PC_B);
      resetModel();
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

      randomCycles(200);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
